cluster_evt_reader: RTL

- One instance per cluster input, upstream of the cluster sync engine.
- Reads the cluster readout FIFO (first-word-fall-through) and parses each event into header, module and footer segments.
- Per segment, advertises a 2-bit availability code and the event L0ID, waits for the engine's WAIT/TX/DROP decision, then forwards the segment (TX) or discards it (DROP).

---
 rtl/cluster_evt_reader.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/cluster_evt_reader.sv
// Cluster event reader: walks the FWFT readout FIFO one event at a time,
// advertising header/module/footer segments to the sync engine and then
// forwarding (TX) or discarding (DROP) each segment as the engine decides.
module cluster_evt_reader #(
  parameter int unsigned DATA_WIDTH   = 65,
  parameter int unsigned EVT_HDR_BITS = 40,
  parameter int unsigned HDR_WORDS    = 3,
  parameter int unsigned FTR_WORDS    = 3,
  parameter logic [7:0]  HDR_FLAG     = 8'hAB,
  parameter logic [7:0]  MOD_FLAG     = 8'h55,
  parameter logic [7:0]  FTR_FLAG     = 8'hCD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [1:0]              evt_available,
  output logic [EVT_HDR_BITS-1:0] evt_l0id,
  input  logic [1:0]              evt_ctrl,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    proto_err,
  output logic [15:0]             err_cnt
);

  localparam int unsigned MAX_WORDS = (HDR_WORDS > FTR_WORDS) ? HDR_WORDS : FTR_WORDS;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_WORDS - 1);
  localparam logic [CNT_W-1:0] FTR_LAST = CNT_W'(FTR_WORDS - 1);

  localparam logic [1:0] AV_NONE   = 2'd0;
  localparam logic [1:0] AV_HDR    = 2'd1;
  localparam logic [1:0] AV_MOD    = 2'd2;
  localparam logic [1:0] AV_FTR    = 2'd3;
  localparam logic [1:0] CTRL_TX   = 2'd1;
  localparam logic [1:0] CTRL_DROP = 2'd2;

  typedef enum logic [3:0] {
    S_EXP_HDR,
    S_HDR_PEND,
    S_HDR_XFER,
    S_GAP,
    S_SEG_SEL,
    S_M_PEND,
    S_M_XFER,
    S_FTR_PEND,
    S_FTR_XFER
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    r_drop;
  logic                    r_after_ftr;
  logic [EVT_HDR_BITS-1:0] r_l0id;
  logic [1:0]              r_avail;
  logic [1:0]              w_avail_next;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_proto_err;
  logic [15:0]             r_err_cnt;

  logic       w_meta;
  logic [7:0] w_flag;
  logic       w_decided;
  logic       w_xfer_rd;
  logic       w_pop;
  logic       w_fwd;
  logic       w_last;
  logic       w_err;
  logic       w_latch;
  logic       w_mode_set;

  assign w_meta    = fifo_dout[DATA_WIDTH-1];
  assign w_flag    = fifo_dout[63:56];
  assign w_decided = (evt_ctrl == CTRL_TX) || (evt_ctrl == CTRL_DROP);
  // DROP drains regardless of the downstream; TX only pops what can be forwarded.
  assign w_xfer_rd = !fifo_empty && (r_drop || out_ready);

  // Next-state, pop and per-cycle event decode.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_pop      = 1'b0;
    w_fwd      = 1'b0;
    w_last     = 1'b0;
    w_err      = 1'b0;
    w_latch    = 1'b0;
    w_mode_set = 1'b0;
    case (r_state)
      S_EXP_HDR: begin
        if (!fifo_empty) begin
          if (w_meta && (w_flag == HDR_FLAG)) begin
            w_latch = 1'b1;
            w_next  = S_HDR_PEND;
          end else begin
            w_pop = 1'b1;
            w_err = 1'b1;
          end
        end
      end
      S_HDR_PEND, S_M_PEND, S_FTR_PEND: begin
        if (w_decided) begin
          w_mode_set = 1'b1;
          w_cnt_next = '0;
          case (r_state)
            S_HDR_PEND: w_next = S_HDR_XFER;
            S_M_PEND:   w_next = S_M_XFER;
            default:    w_next = S_FTR_XFER;
          endcase
        end
      end
      S_HDR_XFER: begin
        if (w_xfer_rd) begin
          w_pop = 1'b1;
          w_fwd = !r_drop;
          if (r_cnt == HDR_LAST) begin
            w_next     = S_GAP;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_M_XFER: begin
        // r_cnt only marks that the start word has gone; the next meta word closes the segment.
        if (!fifo_empty && w_meta && (r_cnt != '0)) begin
          w_next     = S_GAP;
          w_cnt_next = '0;
        end else if (w_xfer_rd) begin
          w_pop      = 1'b1;
          w_fwd      = !r_drop;
          w_cnt_next = CNT_W'(1);
        end
      end
      S_FTR_XFER: begin
        if (w_xfer_rd) begin
          w_pop = 1'b1;
          w_fwd = !r_drop;
          if (r_cnt == FTR_LAST) begin
            w_last     = !r_drop;
            w_next     = S_GAP;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        w_next = r_after_ftr ? S_EXP_HDR : S_SEG_SEL;
      end
      S_SEG_SEL: begin
        if (!fifo_empty) begin
          if (w_meta && (w_flag == MOD_FLAG)) begin
            w_next = S_M_PEND;
          end else if (w_meta && (w_flag == FTR_FLAG)) begin
            w_next = S_FTR_PEND;
          end else if (w_meta && (w_flag == HDR_FLAG)) begin
            w_err  = 1'b1;
            w_next = S_EXP_HDR;
          end else begin
            w_pop = 1'b1;
            w_err = 1'b1;
          end
        end
      end
      default: w_next = S_EXP_HDR;
    endcase
  end

  // Segment code advertised to the engine, derived from the state being entered.
  always_comb begin
    w_avail_next = AV_NONE;
    case (w_next)
      S_HDR_PEND, S_HDR_XFER: w_avail_next = AV_HDR;
      S_M_PEND,   S_M_XFER:   w_avail_next = AV_MOD;
      S_FTR_PEND, S_FTR_XFER: w_avail_next = AV_FTR;
      default:                w_avail_next = AV_NONE;
    endcase
  end

  // FSM state, word counter, transfer mode and event L0ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_EXP_HDR;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_after_ftr <= 1'b0;
      r_l0id      <= '0;
      r_avail     <= AV_NONE;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_avail <= w_avail_next;
      if (w_mode_set) r_drop <= (evt_ctrl == CTRL_DROP);
      if (w_next == S_GAP) r_after_ftr <= (r_state == S_FTR_XFER);
      if (w_latch) r_l0id <= fifo_dout[EVT_HDR_BITS-1:0];
    end
  end

  // Registered output stream and protocol-error reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_proto_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_out_valid <= w_fwd;
      r_out_last  <= w_last;
      r_proto_err <= w_err;
      if (w_fwd) r_out_data <= fifo_dout;
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  // Pops are suppressed while reset is held so an abandoned segment stays in the FIFO.
  assign fifo_rd_en    = w_pop && rst_n;
  assign evt_available = r_avail;
  assign evt_l0id      = r_l0id;
  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_last      = r_out_last;
  assign proto_err     = r_proto_err;
  assign err_cnt       = r_err_cnt;

endmodule
